// File: rtl/result_serializer_if.sv
// Handshake bundle between the matrix-multiply result stream and the byte serializer:
// 18-bit words enter on in_*, bytes leave on out_*, count exposes FIFO occupancy.
interface result_serializer_if #(
    parameter int RES_W = 18
);
    logic             in_valid;
    logic [RES_W-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready;
    logic             out_last;
    logic             done;
    logic [4:0]       count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, done, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, done, count
    );
endinterface

// File: rtl/result_serializer.sv
// Buffers 18-bit matrix results in a first-word-fall-through FIFO and streams each one
// as three bytes (LSB first, top byte zero-padded), marking the last byte of every frame.
module result_serializer #(
    parameter int RES_W   = 18,
    parameter int DEPTH   = 9,
    parameter int N_WORDS = 9
) (
    input  logic               clk,
    input  logic               rst,
    result_serializer_if.slave bus
);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               WC_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [4:0]       DEPTH_C  = 5'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        BYTE_LO  = 2'd0,
        BYTE_MID = 2'd1,
        BYTE_HI  = 2'd2
    } byte_sel_e;

    logic [RES_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;
    byte_sel_e        byte_sel_q, byte_sel_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
    logic             done_q, done_d;

    logic [RES_W-1:0] head;
    logic [7:0]       out_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_last;
    logic             push;
    logic             xfer;
    logic             pop;

    // in_ready is held low during reset so nothing is written while state is being cleared.
    assign in_ready  = rst && (count_q < DEPTH_C);
    assign out_valid = (count_q != 5'd0);
    assign head      = mem_q[rd_ptr_q];
    assign push      = bus.in_valid && in_ready;
    assign xfer      = out_valid && bus.out_ready;
    assign pop       = xfer && (byte_sel_q == BYTE_HI);
    assign out_last  = out_valid && (byte_sel_q == BYTE_HI) && (word_cnt_q == WC_LAST);

    always_comb begin
        // NOTE: every _d signal gets its hold value first, so no branch can leave a latch behind.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        byte_sel_d = byte_sel_q;
        word_cnt_d = word_cnt_q;
        done_d     = xfer && out_last;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end

        if (xfer) begin
            case (byte_sel_q)
                BYTE_LO:  byte_sel_d = BYTE_MID;
                BYTE_MID: byte_sel_d = BYTE_HI;
                default:  byte_sel_d = BYTE_LO;
            endcase
        end

        if (pop) begin
            rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            word_cnt_d = (word_cnt_q == WC_LAST) ? '0 : word_cnt_q + WC_W'(1);
        end

        // A push and a pop in the same cycle leave occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        out_data = head[7:0];
        case (byte_sel_q)
            BYTE_MID: out_data = head[15:8];
            BYTE_HI:  out_data = {6'b0, head[17:16]};
            default:  out_data = head[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            byte_sel_q <= BYTE_LO;
            word_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            byte_sel_q <= byte_sel_d;
            word_cnt_q <= word_cnt_d;
            done_q     <= done_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q gates out_valid, so stale words are never presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bus.done      = done_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: directed scenarios plus a randomized run,
// all compared against a queue-based model of the word/byte stream.
module tb_result_serializer;
    localparam int RES_W   = 18;
    localparam int DEPTH   = 9;
    localparam int N_WORDS = 9;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    result_serializer_if #(.RES_W(RES_W)) bus ();

    result_serializer #(.RES_W(RES_W), .DEPTH(DEPTH), .N_WORDS(N_WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: words waiting to be sent, byte position inside the head word, words sent since reset.
    logic [RES_W-1:0] mq [$];
    int               m_bsel   = 0;
    int               m_popped = 0;
    bit               m_done   = 1'b0;

    function automatic bit m_in_ready();
        return (rst === 1'b1) && (mq.size() < DEPTH);
    endfunction

    function automatic bit m_valid();
        return mq.size() != 0;
    endfunction

    function automatic logic [7:0] m_byte();
        logic [RES_W-1:0] w;
        if (mq.size() == 0) return 8'h00;
        w = mq[0] >> (8 * m_bsel);
        return w[7:0];
    endfunction

    function automatic bit m_last();
        return m_valid() && (m_bsel == 2) && ((m_popped % N_WORDS) == N_WORDS - 1);
    endfunction

    // Advance one clock: update the model from the inputs present at the rising edge.
    task automatic tick();
        bit p, x, l;
        @(posedge clk);
        if (rst !== 1'b1) begin
            mq.delete();
            m_bsel   = 0;
            m_popped = 0;
            m_done   = 1'b0;
        end else begin
            p      = (bus.in_valid === 1'b1) && m_in_ready();
            x      = m_valid() && (bus.out_ready === 1'b1);
            l      = m_last();
            m_done = x && l;
            if (x) begin
                if (m_bsel == 2) begin
                    void'(mq.pop_front());
                    m_bsel = 0;
                    m_popped++;
                end else begin
                    m_bsel++;
                end
            end
            if (p) mq.push_back(bus.in_data);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b1;
        bus.in_data   = 18'h15555;
        bus.out_ready = 1'b1;
        rst = 1'b0;
        tick();
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_held: got %b want 0", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.done !== 1'b0 || bus.count !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_last=%b done=%b count=%0d want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_last, bus.done, bus.count);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] exp_b [3];
        exp_b = '{8'hCD, 8'hAB, 8'h02};
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 18'h2ABCD;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_b[i] || bus.out_last !== 1'b0 ||
                bus.count !== 5'd1) begin
                errors++;
                $display("FAIL single_byte%0d: valid=%b data=%h last=%b count=%0d want 1 %h 0 1",
                         i, bus.out_valid, bus.out_data, bus.out_last, bus.count, exp_b[i]);
            end
            tick();
        end
        checks++;
        if (bus.count !== 5'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: count=%0d valid=%b want 0 0", bus.count, bus.out_valid);
        end
    endtask

    task automatic test_full();
        int n;
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = RES_W'(i);
            tick();
        end
        checks++;
        if (bus.count !== 5'd9 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_after_9: count=%0d in_ready=%b want 9 0", bus.count, bus.in_ready);
        end
        bus.in_data = 18'h0000A;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.count !== 5'd9 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL full_hold%0d: count=%0d in_ready=%b want 9 0", i, bus.count, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.count !== 5'd9 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_cycle: count=%0d in_ready=%b want 9 0", bus.count, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.count !== 5'd8 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_after_pop: count=%0d in_ready=%b want 8 1", bus.count, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.count !== 5'd9) begin
            errors++;
            $display("FAIL full_refill: count=%0d want 9", bus.count);
        end
        bus.in_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 60 && bus.out_valid === 1'b1; c++) begin
            checks++;
            if (bus.out_data !== m_byte() || bus.out_last !== m_last()) begin
                errors++;
                $display("FAIL full_drain_byte%0d: data=%h last=%b want %h %b",
                         n, bus.out_data, bus.out_last, m_byte(), m_last());
            end
            n++;
            tick();
        end
        checks++;
        if (n != 26 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drain_len: bytes=%0d valid=%b want 26 0", n, bus.out_valid);
        end
    endtask

    // Streams a 9-word frame with out_ready high; data is supplied by the caller's queue.
    task automatic run_frame(input string tag, input logic [RES_W-1:0] words [$]);
        int pushed, nbytes, last_cyc, done_cyc, ndone;
        logic [RES_W-1:0] w;
        pushed = 0; nbytes = 0; ndone = 0; last_cyc = -1; done_cyc = -1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            bus.in_valid = (pushed < words.size());
            bus.in_data  = (pushed < words.size()) ? words[pushed] : '0;
            if (bus.out_valid === 1'b1) begin
                w = words[nbytes / 3] >> (8 * (nbytes % 3));
                checks++;
                if (bus.out_data !== w[7:0] || bus.out_last !== (nbytes == 3 * N_WORDS - 1)) begin
                    errors++;
                    $display("FAIL %s_byte%0d: data=%h last=%b want %h %b",
                             tag, nbytes, bus.out_data, bus.out_last, w[7:0], (nbytes == 3 * N_WORDS - 1));
                end
                if (bus.out_last === 1'b1) last_cyc = c;
                nbytes++;
            end
            checks++;
            if (bus.done !== m_done) begin
                errors++;
                $display("FAIL %s_done_cyc%0d: got %b want %b", tag, c, bus.done, m_done);
            end
            if (bus.done === 1'b1) begin
                ndone++;
                done_cyc = c;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) pushed++;
            tick();
        end
        checks++;
        if (nbytes != 3 * N_WORDS || ndone != 1 || done_cyc != last_cyc + 1 || bus.count !== 5'd0) begin
            errors++;
            $display("FAIL %s_summary: bytes=%0d done_pulses=%0d last_cyc=%0d done_cyc=%0d count=%0d want 27 1 done=last+1 0",
                     tag, nbytes, ndone, last_cyc, done_cyc, bus.count);
        end
    endtask

    task automatic test_frame();
        logic [RES_W-1:0] words [$];
        for (int i = 0; i < N_WORDS; i++) words.push_back(18'h3FFFF);
        do_reset();
        run_frame("frame", words);
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 18'h01234;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_data !== 8'h34) begin
            errors++;
            $display("FAIL bp_byte0: got %h want 34", bus.out_data);
        end
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h12 || bus.out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: valid=%b data=%h last=%b want 1 12 0",
                         i, bus.out_valid, bus.out_data, bus.out_last);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        checks++;
        if (bus.out_data !== 8'h12) begin
            errors++;
            $display("FAIL bp_resume: got %h want 12", bus.out_data);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00) begin
            errors++;
            $display("FAIL bp_byte2: valid=%b data=%h want 1 00", bus.out_valid, bus.out_data);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 5'd0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b count=%0d want 0 0", bus.out_valid, bus.count);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = RES_W'($urandom);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = RES_W'($urandom);
        checks++;
        if (bus.count !== 5'd4) begin
            errors++;
            $display("FAIL simul_before: count=%0d want 4", bus.count);
        end
        tick();
        checks++;
        if (bus.count !== 5'd4) begin
            errors++;
            $display("FAIL simul_push_pop: count=%0d want 4", bus.count);
        end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = RES_W'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.count !== 5'd9) begin
            errors++;
            $display("FAIL simul_fill: count=%0d want 9", bus.count);
        end
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = RES_W'($urandom);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.count !== 5'd9) begin
            errors++;
            $display("FAIL simul_full_refuse: in_ready=%b count=%0d want 0 9", bus.in_ready, bus.count);
        end
        tick();
        checks++;
        if (bus.count !== 5'd8 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_full_pop: count=%0d in_ready=%b want 8 1", bus.count, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 60 && bus.out_valid === 1'b1; c++) begin
            checks++;
            if (bus.out_data !== m_byte()) begin
                errors++;
                $display("FAIL simul_order_byte%0d: got %h want %h", n, bus.out_data, m_byte());
            end
            n++;
            tick();
        end
        checks++;
        if (n != 26 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain_len: bytes=%0d valid=%b want 26 0", n, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [RES_W-1:0] words [$];
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = RES_W'($urandom);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.count !== 5'd0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: count=%0d valid=%b done=%b want 0 0 0",
                     bus.count, bus.out_valid, bus.done);
        end
        for (int i = 0; i < N_WORDS; i++) words.push_back(RES_W'($urandom));
        run_frame("midrst_frame", words);
    endtask

    task automatic test_random();
        bit acc;
        do_reset();
        acc = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!(bus.in_valid === 1'b1 && !acc)) begin
                bus.in_valid = ($urandom_range(0, 99) < 60);
                bus.in_data  = RES_W'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 99) < 70);
            checks++;
            if (bus.count !== 5'(mq.size()) || bus.in_ready !== m_in_ready() || bus.out_valid !== m_valid() ||
                bus.out_last !== m_last() || bus.done !== m_done) begin
                errors++;
                $display("FAIL rand_ctrl_cyc%0d: count=%0d rdy=%b vld=%b last=%b done=%b want %0d %b %b %b %b",
                         c, bus.count, bus.in_ready, bus.out_valid, bus.out_last, bus.done,
                         mq.size(), m_in_ready(), m_valid(), m_last(), m_done);
            end
            if (m_valid()) begin
                checks++;
                if (bus.out_data !== m_byte()) begin
                    errors++;
                    $display("FAIL rand_data_cyc%0d: got %h want %h", c, bus.out_data, m_byte());
                end
            end
            acc = (bus.in_valid === 1'b1) && m_in_ready();
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        test_reset();
        test_single_word();
        test_full();
        test_frame();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
